// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the regfile write port between NREQ writeback
// requesters and tracks pending destinations. Optional macro: REGFILE_WB_BYPASS_EN.
`ifndef ENABLE
`define ENABLE 1'b1
`endif

module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_rd_src,
  input  logic [NREQ*XLEN-1:0] req_rd,
  input  logic                 alloc_valid,
  input  logic [4:0]           alloc_rd_src,
  output logic                 reg_we,
  output logic [4:0]           rd_src,
  output logic [XLEN-1:0]      rd,
  output logic [31:0]          busy_mask
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd_src,
  output logic [XLEN-1:0]      fwd_rd
`endif
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            grant_any;
  logic [4:0]      grant_src;
  logic [XLEN-1:0] grant_data;
  logic            we_q, we_d;
  logic [4:0]      rd_src_q, rd_src_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic [31:0]     busy_q, busy_d;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    int idx;
    idx        = 0;
    grant_any  = 1'b0;
    grant_src  = '0;
    grant_data = '0;
    req_ready  = '0;
    ptr_d      = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any      = 1'b1;
        grant_src      = req_rd_src[5*idx +: 5];
        grant_data     = req_rd[XLEN*idx +: XLEN];
        req_ready[idx] = 1'b1;
        ptr_d          = PW'(idx);
      end
    end
  end

  always_comb begin
    we_d     = grant_any && (grant_src != 5'd0);
    rd_src_d = grant_any ? grant_src : rd_src_q;
    rd_d     = grant_any ? grant_data : rd_q;
  end

  // Clear first, then set, so a new producer on the retiring index keeps the bit.
  always_comb begin
    busy_d = busy_q;
`ifdef REGFILE_WB_BYPASS_EN
    if (grant_any && (grant_src != 5'd0)) busy_d[grant_src] = 1'b0;
`else
    if (we_q) busy_d[rd_src_q] = 1'b0;
`endif
    if (alloc_valid && (alloc_rd_src != 5'd0)) busy_d[alloc_rd_src] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= PW'(NREQ - 1);
      we_q     <= 1'b0;
      rd_src_q <= '0;
      rd_q     <= '0;
      busy_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      we_q     <= we_d;
      rd_src_q <= rd_src_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
    end
  end

  assign reg_we    = we_q ? `ENABLE : ~`ENABLE;
  assign rd_src    = rd_src_q;
  assign rd        = rd_q;
  assign busy_mask = busy_q;

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd_valid  = grant_any && (grant_src != 5'd0);
  assign fwd_rd_src = grant_src;
  assign fwd_rd     = grant_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized
// traffic against a behavioural model of the round-robin writeback port.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 2;
  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_rd_src;
  logic [NREQ*XLEN-1:0] req_rd;
  logic                 alloc_valid;
  logic [4:0]           alloc_rd_src;
  logic                 reg_we;
  logic [4:0]           rd_src;
  logic [XLEN-1:0]      rd;
  logic [31:0]          busy_mask;
`ifdef REGFILE_WB_BYPASS_EN
  logic                 fwd_valid;
  logic [4:0]           fwd_rd_src;
  logic [XLEN-1:0]      fwd_rd;
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd_src(req_rd_src), .req_rd(req_rd),
    .alloc_valid(alloc_valid), .alloc_rd_src(alloc_rd_src),
    .reg_we(reg_we), .rd_src(rd_src), .rd(rd), .busy_mask(busy_mask)
`ifdef REGFILE_WB_BYPASS_EN
    , .fwd_valid(fwd_valid), .fwd_rd_src(fwd_rd_src), .fwd_rd(fwd_rd)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid    = '0;
    req_rd_src   = '0;
    req_rd       = '0;
    alloc_valid  = 1'b0;
    alloc_rd_src = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_req(input int i, input logic [4:0] s, input logic [XLEN-1:0] d);
    req_valid[i]            = 1'b1;
    req_rd_src[5*i +: 5]    = s;
    req_rd[XLEN*i +: XLEN]  = d;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", reg_we); end
    checks++; if (rd_src !== 5'd0) begin errors++; $display("FAIL reset_rd_src got %0d want 0", rd_src); end
    checks++; if (rd !== '0) begin errors++; $display("FAIL reset_rd got %h want 0", rd); end
    checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", busy_mask); end
    drive_req(0, 5'd1, 32'h1);
    drive_req(1, 5'd2, 32'h2);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", req_ready); end
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    drive_req(0, 5'd3, 32'hDEADBEEF);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
    tick();
    idle_inputs();
    checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL single_we got %0b want 1", reg_we); end
    checks++; if (rd_src !== 5'd3) begin errors++; $display("FAIL single_rd_src got %0d want 3", rd_src); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rd got %h want deadbeef", rd); end
    tick();
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL single_we_drop got %0b want 0", reg_we); end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] want;
    do_reset();
    drive_req(0, 5'd1, 32'h11);
    drive_req(1, 5'd2, 32'h22);
    for (int c = 0; c < 4; c++) begin
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (req_ready !== want) begin errors++; $display("FAIL contention_grant%0d got %b want %b", c, req_ready, want); end
      tick();
      checks++; if (reg_we !== 1'b1 || rd_src !== ((c % 2 == 0) ? 5'd1 : 5'd2)) begin
        errors++; $display("FAIL contention_write%0d got we=%0b src=%0d want we=1 src=%0d", c, reg_we, rd_src, (c % 2 == 0) ? 1 : 2);
      end
    end
    idle_inputs();
  endtask

  task automatic test_x0();
    do_reset();
    alloc_valid = 1'b1; alloc_rd_src = 5'd5;
    tick();
    alloc_valid = 1'b0;
    checks++; if (busy_mask !== 32'h20) begin errors++; $display("FAIL x0_alloc got %h want 00000020", busy_mask); end
    drive_req(0, 5'd0, 32'hCAFE);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL x0_ready got %b want 01", req_ready); end
    tick();
    idle_inputs();
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL x0_we got %0b want 0", reg_we); end
    tick();
    checks++; if (busy_mask !== 32'h20) begin errors++; $display("FAIL x0_busy got %h want 00000020", busy_mask); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    alloc_valid = 1'b1; alloc_rd_src = 5'd7;
    tick();
    alloc_valid = 1'b0;
    checks++; if (busy_mask[7] !== 1'b1) begin errors++; $display("FAIL sb_set got %0b want 1", busy_mask[7]); end
    drive_req(0, 5'd7, 32'hA5A5);
    tick();
    idle_inputs();
    checks++; if (busy_mask[7] !== !BYP) begin errors++; $display("FAIL sb_clear_early got %0b want %0b", busy_mask[7], !BYP); end
    tick();
    checks++; if (busy_mask[7] !== 1'b0) begin errors++; $display("FAIL sb_clear got %0b want 0", busy_mask[7]); end
    alloc_valid = 1'b1; alloc_rd_src = 5'd7;
    tick();
    alloc_valid = 1'b0;
    drive_req(0, 5'd7, 32'h5A5A);
    if (BYP) begin alloc_valid = 1'b1; alloc_rd_src = 5'd7; end
    tick();
    idle_inputs();
    if (!BYP) begin alloc_valid = 1'b1; alloc_rd_src = 5'd7; end
    tick();
    idle_inputs();
    checks++; if (busy_mask[7] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %0b want 1", busy_mask[7]); end
    tick();
    checks++; if (busy_mask[7] !== 1'b1) begin errors++; $display("FAIL sb_set_holds got %0b want 1", busy_mask[7]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_valid = 1'b1; alloc_rd_src = 5'd5;
    drive_req(0, 5'd5, 32'h55);
    tick();
    idle_inputs();
    checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL midrst_pre_we got %0b want 1", reg_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (reg_we !== 1'b0 || busy_mask !== 32'd0) begin
      errors++; $display("FAIL midrst_clear got we=%0b busy=%h want we=0 busy=0", reg_we, busy_mask);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL midrst_after got %0b want 0", reg_we); end
  endtask

`ifdef REGFILE_WB_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    alloc_valid = 1'b1; alloc_rd_src = 5'd9;
    tick();
    alloc_valid = 1'b0;
    drive_req(1, 5'd9, 32'h1234);
    #1;
    checks++; if (fwd_valid !== 1'b1 || fwd_rd_src !== 5'd9 || fwd_rd !== 32'h1234) begin
      errors++; $display("FAIL bypass_fwd got v=%0b src=%0d rd=%h want 1 9 1234", fwd_valid, fwd_rd_src, fwd_rd);
    end
    tick();
    idle_inputs();
    checks++; if (busy_mask[9] !== 1'b0 || reg_we !== 1'b1) begin
      errors++; $display("FAIL bypass_clear got busy9=%0b we=%0b want 0 1", busy_mask[9], reg_we);
    end
  endtask
`endif

  task automatic test_random();
    bit              pend [NREQ];
    logic [4:0]      psrc [NREQ];
    logic [XLEN-1:0] pdat [NREQ];
    int              last, g;
    logic            e_we;
    logic [4:0]      e_src;
    logic [XLEN-1:0] e_rd;
    logic [31:0]     e_busy, nb;
    logic [NREQ-1:0] e_ready;
    do_reset();
    last = NREQ - 1; e_we = 0; e_src = 0; e_rd = 0; e_busy = 0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; psrc[i] = 0; pdat[i] = 0; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      checks++; if (reg_we !== e_we) begin errors++; $display("FAIL rnd_we c%0d got %0b want %0b", cyc, reg_we, e_we); end
      checks++; if (e_we && (rd_src !== e_src || rd !== e_rd)) begin
        errors++; $display("FAIL rnd_data c%0d got %0d/%h want %0d/%h", cyc, rd_src, rd, e_src, e_rd);
      end
      checks++; if (busy_mask !== e_busy) begin errors++; $display("FAIL rnd_busy c%0d got %h want %h", cyc, busy_mask, e_busy); end
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1;
          psrc[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pdat[i] = $urandom;
        end
        req_valid[i]           = pend[i];
        req_rd_src[5*i +: 5]   = psrc[i];
        req_rd[XLEN*i +: XLEN] = pdat[i];
      end
      alloc_valid  = ($urandom_range(0, 1) == 1);
      alloc_rd_src = 5'($urandom_range(0, 31));
      g = -1;
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && pend[(last + k) % NREQ]) g = (last + k) % NREQ;
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      #1;
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d got %b want %b", cyc, req_ready, e_ready); end
`ifdef REGFILE_WB_BYPASS_EN
      checks++; if (fwd_valid !== (g >= 0 && psrc[g] != 0)) begin
        errors++; $display("FAIL rnd_fwd c%0d got %0b", cyc, fwd_valid);
      end
`endif
      nb = e_busy;
      if (BYP) begin
        if (g >= 0 && psrc[g] != 0) nb[psrc[g]] = 1'b0;
      end else if (e_we) nb[e_src] = 1'b0;
      if (alloc_valid && alloc_rd_src != 0) nb[alloc_rd_src] = 1'b1;
      nb[0] = 1'b0;
      e_busy = nb;
      e_we = (g >= 0) && (psrc[g] != 0);
      if (g >= 0) begin
        e_src = psrc[g]; e_rd = pdat[g]; pend[g] = 0; last = g;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_scoreboard();
    test_reset_mid();
`ifdef REGFILE_WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
